word_serializer: RTL
====================

// Module: word_serializer
// PURPOSE
//  - Unloads one DATA_WIDTH word per transaction and emits it as NUM_CHUNKS = DATA_WIDTH/CHUNK_WIDTH
//    narrow chunks over a valid/ready stream.
//  - It is the read-out end of the 32-bit enabled word registers in the DCNN datapath.
//  - It feeds narrow downstream consumers such as memory write ports and the result/debug egress.
// PARAMETERS
//  DATA_WIDTH   32  width of loaded word; must be a multiple of CHUNK_WIDTH
//  CHUNK_WIDTH  8   width of each emitted chunk; NUM_CHUNKS = DATA_WIDTH/CHUNK_WIDTH >= 1
//  MSB_FIRST    0   0: chunk 0 = Din[CHUNK_WIDTH-1:0] first; 1: most-significant chunk first
// PORTS
//  CLK        in   1            single clock; all state updates on its rising edge
//  RST        in   1            asynchronous, active-high reset
//  in_valid   in   1            Din holds a word to load
//  in_ready   out  1            block can accept Din this cycle
//  Din        in   DATA_WIDTH   word to serialize; sampled only on in_valid&in_ready
//  out_valid  out  1            Dout holds a valid chunk
//  out_ready  in   1            downstream accepts Dout this cycle
//  Dout       out  CHUNK_WIDTH  current chunk
//  out_last   out  1            current chunk is the final chunk of its word (qualified by out_valid)
//  busy       out  1            a word is held (equals out_valid)
// BEHAVIOUR
//  - Reset (async, RST=1): state=IDLE, shift register=0, chunk counter=0.
//    Outputs: out_valid=0, out_last=0, Dout=0, busy=0, in_ready=0 while RST=1.
//  - A word in progress is discarded on reset; nothing is emitted after RST deasserts until a new load.
//  - States:
//    - IDLE: in_ready=1. On in_valid -> load Din, counter=0, go SEND.
//    - SEND: out_valid=1; Dout = selected chunk.
//      - Handshake: out_valid&out_ready accepts a chunk; counter increments.
//      - When the accepted chunk is the last one (counter == NUM_CHUNKS-1):
//        - in_valid=1 -> load Din that same edge, counter=0, stay SEND (zero-bubble back-to-back).
//        - in_valid=0 -> go IDLE.
//  - in_ready = (state==IDLE) | (state==SEND & out_ready & out_last). This is combinational from
//    out_ready; there is no combinational path from in_valid to out_valid.
//  - Latency: word loaded at edge N -> first chunk valid in cycle N+1. With out_ready held at 1,
//    a word occupies exactly NUM_CHUNKS cycles; sustained throughput is 1 chunk/cycle.
//  - Back-pressure: while out_valid=1 & out_ready=0, Dout, out_last and the counter hold stable.
//    out_valid never drops before the chunk is accepted.
//  - out_last=1 iff SEND & counter==NUM_CHUNKS-1. If NUM_CHUNKS==1, every chunk is last.
//  - Chunk select: LSB-first emits Din[k*CW +: CW] at count k. MSB_FIRST emits
//    Din[(NUM_CHUNKS-1-k)*CW +: CW]. Implemented as a shift of the held word, not a wide mux.
//  - Counter width = max(1, clog2(NUM_CHUNKS)). It wraps only via reload, never by overflow.
//  - Din is ignored when in_ready=0. in_valid may drop without acceptance (no input stickiness).
//  - Elaboration check: DATA_WIDTH % CHUNK_WIDTH != 0 is a fatal error.
// STRUCTURE
//  - Shared package dcnn_pkg:
//    - WORD_WIDTH=32
//    - state encoding localparams ST_IDLE=1'b0, ST_SEND=1'b1
//    - function clog2
//  - One sub-module, chunk_counter (load/clear, inc, terminal-count flag last), built on the
//    same enabled-register cells as the datapath.
//  - Shift register and FSM live in this module.
// TESTING
//  1. Reset mid-word: load 32'hDEADBEEF, accept 2 chunks, assert RST for 1 cycle
//     -> out_valid=0 at once; after release no further chunks; next load restarts at chunk 0.
//  2. Streaming LSB-first, out_ready=1: load 32'hA1B2C3D4
//     -> Dout = D4,C3,B2,A1 in 4 consecutive cycles; out_last only on A1; then IDLE.
//  3. MSB_FIRST=1, same word
//     -> A1,B2,C3,D4; out_last on D4.
//  4. Back-to-back: in_valid held with 32'h11223344 then 32'h55667788, out_ready=1
//     -> 8 chunks in 8 cycles, no bubble; in_ready pulses only with out_last.
//  5. Back-pressure: out_ready toggled randomly/held low 5 cycles mid-word
//     -> Dout and out_last stable while stalled; no chunk lost or duplicated (scoreboard).
//  6. CHUNK_WIDTH=32 (NUM_CHUNKS=1): load 32'h0000FFFF
//     -> one chunk with out_last=1; a new word can be accepted every cycle.

Source files
------------

// File: rtl/dcnn_pkg.sv
// Shared DCNN datapath definitions: word width, serializer state encoding and a
// constant-foldable ceil(log2) helper.
package dcnn_pkg;

    localparam int unsigned WORD_WIDTH = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/chunk_counter.sv
// Chunk index counter: synchronous clear on load, enabled increment, and a
// terminal-count flag for the final chunk of a word.
module chunk_counter
    import dcnn_pkg::*;
#(
    parameter int unsigned NUM   = 4,
    parameter int unsigned CNT_W = (clog2(NUM) > 0) ? clog2(NUM) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic last_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over increment so a reload always restarts at chunk 0.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_c = (cnt_q == CNT_W'(NUM - 1));

endmodule

// File: rtl/word_serializer.sv
// Loads one wide word and streams it out as NUM_CHUNKS narrow chunks over a
// valid/ready interface, with zero-bubble back-to-back reloads.
module word_serializer
    import dcnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = WORD_WIDTH,
    parameter int unsigned CHUNK_WIDTH = 8,
    parameter bit          MSB_FIRST   = 1'b0
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  Din,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CHUNK_WIDTH-1:0] Dout,
    output logic                   out_last,
    output logic                   busy
);

    localparam int unsigned NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;

    if (DATA_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_width
        $fatal(1, "word_serializer: DATA_WIDTH must be a multiple of CHUNK_WIDTH");
    end

    state_e                state_q;
    state_e                state_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  load;
    logic                  accept;
    logic                  cnt_last;

    // The emitted chunk always sits at one fixed end of the held word.
    if (NUM_CHUNKS == 1) begin : g_single
        assign shift_next = shift_q;
    end else if (MSB_FIRST) begin : g_msb
        assign shift_next = {shift_q[DATA_WIDTH-CHUNK_WIDTH-1:0], {CHUNK_WIDTH{1'b0}}};
    end else begin : g_lsb
        assign shift_next = {{CHUNK_WIDTH{1'b0}}, shift_q[DATA_WIDTH-1:CHUNK_WIDTH]};
    end

    assign out_valid = (state_q == ST_SEND);
    assign busy      = out_valid;
    assign out_last  = out_valid & cnt_last;
    assign accept    = out_valid & out_ready;
    assign Dout      = MSB_FIRST ? shift_q[DATA_WIDTH-1 -: CHUNK_WIDTH] : shift_q[CHUNK_WIDTH-1:0];
    assign in_ready  = ~RST & ((state_q == ST_IDLE) | (accept & cnt_last));

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_ready && cnt_last) begin
                    if (in_valid) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The last chunk is never shifted out so a reload sees a clean hand-over.
    always_comb begin
        shift_d = shift_q;
        if (load) begin
            shift_d = Din;
        end else if (accept && !cnt_last) begin
            shift_d = shift_next;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
        end
    end

    chunk_counter #(
        .NUM (NUM_CHUNKS)
    ) u_chunk_counter (
        .clk    (CLK),
        .rst    (RST),
        .clr    (load),
        .inc    (accept & ~cnt_last),
        .last_c (cnt_last)
    );

endmodule
